// File: rtl/sub_divide_ctrl.sv
// sub_divide_ctrl
// Repeated-subtraction unsigned divider controller. The datapath subtractor is
// external: this block presents minuend/subtrahend and consumes the
// difference and final borrow, counting successful subtractions as the
// quotient until a borrow shows the remainder is smaller than the divisor.
module sub_divide_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  output logic             sub_bin,
  input  logic [WIDTH-1:0] sub_d,
  input  logic             sub_bout,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] quot_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;

  // Subtractor operands come straight from the working registers; the
  // borrow-in is tied low so the subtractor computes rem_r - dvs_r.
  assign sub_a       = rem_r;
  assign sub_b       = dvs_r;
  assign sub_bin     = 1'b0;

  assign quotient    = quot_r;
  assign remainder   = rem_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;

  // Control FSM with registered status outputs and the working registers.
  // A zero divisor still passes through SUB for one cycle (terminating
  // without touching the operands) so that its done pulse lands one edge
  // after acceptance, same as a division whose quotient is zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      rem_r   <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
      quot_r  <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            rem_r   <= dividend;
            dvs_r   <= divisor;
            busy_r  <= 1'b1;
            state_r <= SUB;
            if (divisor == {WIDTH{1'b0}}) begin
              quot_r <= {WIDTH{1'b1}};
              dbz_r  <= 1'b1;
            end else begin
              quot_r <= {WIDTH{1'b0}};
              dbz_r  <= 1'b0;
            end
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        SUB: begin
          if (dbz_r || sub_bout) begin
            // Remainder is below the divisor (or there is nothing to divide
            // by): results are final.
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            rem_r  <= sub_d;
            quot_r <= quot_r + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_divide_ctrl.sv
// tb_sub_divide_ctrl
// Scoreboard bench: the driver pushes the arithmetically expected result and
// completion cycle for every accepted start; a monitor pops on each done
// pulse. The external subtractor is modelled here with plain arithmetic.
module tb_sub_divide_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] sub_a;
  logic [3:0] sub_b;
  logic       sub_bin;
  logic [3:0] sub_d;
  logic       sub_bout;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  typedef struct {
    int q;
    int r;
    int dbz;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   last_q = 0;
  int   last_r = 0;
  int   last_dbz = 0;

  sub_divide_ctrl #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .sub_a       (sub_a),
    .sub_b       (sub_b),
    .sub_bin     (sub_bin),
    .sub_d       (sub_d),
    .sub_bout    (sub_bout),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  // External 4-bit subtractor: 5-bit difference, top bit is the borrow-out.
  logic [4:0] diff5;
  assign diff5    = {1'b0, sub_a} - {1'b0, sub_b} - {4'b0000, sub_bin};
  assign sub_d    = diff5[3:0];
  assign sub_bout = diff5[4];

  always #5 clk = ~clk;

  // Cycle counter: after edge N, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each done pulse, checks result and timing,
  // flags overdue completions and checks that results hold while idle.
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("quotient", int'(quotient), e.q);
          chk("remainder", int'(remainder), e.r);
          chk("div_by_zero", int'(div_by_zero), e.dbz);
          chk("busy_at_done", int'(busy), 1);
          last_q   = e.q;
          last_r   = e.r;
          last_dbz = e.dbz;
        end
      end else begin
        if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
          chk("done_timeout", cyc, sbq[0].cyc);
          void'(sbq.pop_front());
        end
        if (busy === 1'b0) begin
          chk("hold_quotient", int'(quotient), last_q);
          chk("hold_remainder", int'(remainder), last_r);
          chk("hold_div_by_zero", int'(div_by_zero), last_dbz);
        end
      end
    end
  end

  // Drive a start at the current negedge (DUT idle) and record the expected
  // outcome from plain integer division.
  task automatic issue(input int a, input int b);
    exp_t e;
    dividend = 4'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    if (b == 0) begin
      e.q = 15; e.r = a; e.dbz = 1; e.cyc = cyc + 1 + 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 0; e.cyc = cyc + 1 + (a / b) + 1;
    end
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait until idle; optionally scribble on start/operands while busy.
  task automatic wait_idle(input bit noise);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (noise) begin
        start    = 1'($urandom_range(0, 1));
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (busy !== 1'b0) chk("busy_timeout", int'(busy), 0);
  endtask

  task automatic do_div(input int a, input int b, input bit noise);
    issue(a, b);
    wait_idle(noise);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_quotient"}, int'(quotient), 0);
    chk({tag, "_remainder"}, int'(remainder), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_div_by_zero"}, int'(div_by_zero), 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 4'd7;
    divisor  = 4'd2;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    do_div(13, 4, 1'b0);
    do_div(15, 1, 1'b0);
    do_div(3, 7, 1'b0);
    do_div(6, 6, 1'b0);
    do_div(9, 0, 1'b0);
    do_div(0, 5, 1'b0);
    do_div(0, 0, 1'b0);

    // Start while busy is ignored, not queued.
    issue(15, 1);
    repeat (2) @(negedge clk);
    start    = 1'b1;
    dividend = 4'd2;
    divisor  = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(1'b0);

    // Reset in the middle of an operation.
    issue(15, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    last_q = 0; last_r = 0; last_dbz = 0;
    @(negedge clk);
    chk_zero("midreset");
    rst = 1'b0;
    @(negedge clk);
    do_div(8, 2, 1'b0);

    // Randomized divisions with junk on inputs while busy.
    for (int i = 0; i < 50; i++) begin
      int a, b;
      a = int'($urandom_range(0, 15));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
      do_div(a, b, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
